divider_seq_n_bits: RTL and testbench
=====================================

# divider_seq_n_bits

Iterative unsigned restoring divider that computes an N-bit quotient and an N-bit remainder, one quotient bit per clock. It is the inverse operation of the team's combinational N-bit array multiplier: for every non-zero divisor, Q*B + R == A and R < B. A start/busy/done handshake lets a controller issue operations back to back. It is used wherever the datapath has to undo a product or scale a value down without a large combinational divider array.

## Interface
- N, 4, operand width in bits; legal range 2..32

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low; one clock; reset is synchronous and active-low
- start  input  1  request a division; sampled only in IDLE or DONE
- A  input  N  dividend, unsigned; captured on the accepting edge
- B  input  N  divisor, unsigned; captured on the accepting edge
- Q  output  N  quotient; registered
- R  output  N  remainder; registered
- busy  output  1  high while an iteration is in progress (RUN)
- done  output  1  single-cycle pulse; Q, R and dbz are valid
- dbz  output  1  divide-by-zero flag for the latest result; registered

## Operation
- States: IDLE, RUN, DONE. Reset (rst_n=0 at an edge) forces:
  - state IDLE;
  - Q=0, R=0, busy=0, done=0, dbz=0;
  - internal dividend register, divisor register and counter all 0.
- Reset has priority over every other input, including a division already in RUN. An aborted division produces no done pulse.
- IDLE, start=1:
  - B!=0: latch the dividend into the shift register D and the divisor into V; set partial remainder P=0 (N+1 bits) and counter=N; go to RUN.
  - B==0: load Q={N{1}}, R=A, dbz=1; go to DONE. No RUN cycles.
- RUN, each cycle:
  - T = {P[N-1:0], D[N-1]} - {1'b0, V}, computed N+1 bits wide.
  - If T[N]==0: P=T and shift 1 into the D LSB. Otherwise P keeps the shifted value {P[N-1:0], D[N-1]} and 0 is shifted in.
  - D shifts left, so after N steps it holds the quotient.
  - counter decrements by 1. When counter reaches 1 in this cycle: Q=D (final), R=P[N-1:0], dbz=0; go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1: accepted exactly as in IDLE (back-to-back operation).
  - Otherwise: go to IDLE.
- start is ignored in RUN; A and B may change freely during RUN.
- Q, R and dbz keep their last result until the next result is written. They do not change during RUN.

## Timing
- Accepting edge t (start=1, B!=0):
  - busy=1 from after edge t through edge t+N.
  - The last iteration is at edge t+N.
  - done=1 and Q/R valid in the cycle after edge t+N.
  - Latency is N+1 cycles from the start edge to done sampled high.
- Divide by zero: done=1 in the cycle after the accepting edge t (latency 1); busy stays 0.
- Throughput with start held high: one result every N+1 cycles; the new start is accepted on the DONE edge.
- busy and done are never high together. done is never high for two consecutive cycles unless successive operations are divide-by-zero.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- N=4, A=13, B=3 -> Q=4, R=1, dbz=0; done seen exactly 5 cycles after the start edge; busy high for 4 cycles.
- N=4, A=15, B=1 -> Q=15, R=0. Then A=2, B=5 -> Q=0, R=2. Then A=15, B=15 -> Q=1, R=0.
- N=4, A=7, B=0 -> Q=15, R=7, dbz=1, done one cycle after start, busy never high. A following 9/2 -> Q=4, R=1, dbz=0.
- start held high with 13/3, then A and B switched to 9/4 during RUN -> first result 4/1; 9/4 accepted on the DONE edge -> 2/1; start pulses during RUN have no effect.
- rst_n=0 for one edge at the second RUN cycle -> all outputs 0 and state IDLE on the next cycle; no done pulse; a new 6/4 afterwards -> Q=1, R=2.
- Exhaustive sweep at N=4 (all A, all B!=0) plus random operands at N=8 -> Q*B+R==A and R<B for every result.

Source files
------------

// File: rtl/divider_seq_n_bits.sv
// divider_seq_n_bits: iterative unsigned restoring divider, one quotient bit per clock
module divider_seq_n_bits #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         dbz
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [N-1:0] d, v, p, p_n, d_n;
    logic [N:0] sh, t;
    logic [CW-1:0] cnt;
    logic accept, last;
    // trial subtraction of the shifted partial remainder and next-state decode
    always_comb begin
        sh = {p, d[N-1]};
        t = sh - {1'b0, v};
        p_n = t[N] ? sh[N-1:0] : t[N-1:0];
        d_n = {d[N-2:0], ~t[N]};
        accept = start && state != RUN;
        last = state == RUN && cnt == CW'(1);
        state_n = accept ? (B == '0 ? DONE : RUN) : state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    // state, iteration datapath and registered results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            dbz <= 1'b0;
            Q <= '0;
            R <= '0;
            d <= '0;
            v <= '0;
            p <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            busy <= state_n == RUN;
            done <= state_n == DONE;
            if (accept) begin
                if (B == '0) begin
                    Q <= '1;
                    R <= A;
                    dbz <= 1'b1;
                end else begin
                    d <= A;
                    v <= B;
                    p <= '0;
                    cnt <= CW'(N);
                end
            end else if (state == RUN) begin
                p <= p_n;
                d <= d_n;
                cnt <= cnt - CW'(1);
                if (last) begin
                    Q <= d_n;
                    R <= p_n;
                    dbz <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_divider_seq_n_bits.sv
// tb_divider_seq_n_bits: scoreboard bench for the sequential divider at N=4 and N=8
module tb_divider_seq_n_bits;
    logic clk = 0, rst_n = 0, start = 0, start8 = 0;
    logic [3:0] a = 0, b = 0, q, r;
    logic [7:0] a8 = 0, b8 = 0, q8, r8;
    logic busy, done, dbz, busy8, done8, dbz8;
    int checks = 0, fails = 0;
    typedef struct {logic [7:0] q; logic [7:0] r; logic z; int l; longint t;} exp_t;
    exp_t sb[$], sb8[$];

    divider_seq_n_bits #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
        .Q(q), .R(r), .busy(busy), .done(done), .dbz(dbz));
    divider_seq_n_bits #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .Q(q8), .R(r8), .busy(busy8), .done(done8), .dbz(dbz8));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input int n, input logic [7:0] x, input logic [7:0] y, input longint t);
        exp_t e;
        e.t = t;
        e.l = (y == 0) ? 1 : n + 1;
        if (y == 0) begin
            e.q = 8'((1 << n) - 1);
            e.r = x;
            e.z = 1;
        end else begin
            e.q = x / y;
            e.r = x % y;
            e.z = 0;
        end
        return e;
    endfunction

    task automatic check_result(input string tag, input logic [7:0] qq, input logic [7:0] rr,
                                input logic zz, input exp_t e);
        chk({tag, "_q"}, qq, e.q);
        chk({tag, "_r"}, rr, e.r);
        chk({tag, "_dbz"}, zz, e.z);
        chk({tag, "_latency"}, ($time - e.t - 5) / 10 + 1, e.l);
    endtask

    always @(negedge clk) begin : mon4
        if (rst_n) begin
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else check_result("n4", {4'b0, q}, {4'b0, r}, dbz, sb.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon8
        if (rst_n && done8) begin
            if (sb8.size() == 0) chk("unexpected_done8", 1, 0);
            else check_result("n8", q8, r8, dbz8, sb8.pop_front());
        end
    end

    task automatic issue(input logic [3:0] x, input logic [3:0] y, input bit hold, output longint t);
        @(negedge clk);
        start = 1;
        a = x;
        b = y;
        @(posedge clk);
        t = $time;
        sb.push_back(model(4, x, y, t));
        #1;
        if (!hold) start = 0;
    endtask

    task automatic wait_done(output int bc);
        int k = 0;
        bc = 0;
        do begin
            @(negedge clk);
            bc += int'(busy);
            k++;
        end while (!done && k < 40);
        if (!done) chk("done_timeout", 1, 0);
    endtask

    task automatic op(input logic [3:0] x, input logic [3:0] y);
        longint t;
        int bc;
        issue(x, y, 0, t);
        wait_done(bc);
        chk("busy_cycles", bc, (y == 0) ? 0 : 4);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y);
        int k = 0;
        @(negedge clk);
        start8 = 1;
        a8 = x;
        b8 = y;
        @(posedge clk);
        sb8.push_back(model(8, x, y, $time));
        #1;
        start8 = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done8 && k < 40);
        if (!done8) chk("done8_timeout", 1, 0);
        else if (y != 0) begin
            chk("n8_identity", 16'(q8) * 16'(y) + 16'(r8), 16'(x));
            chk("n8_rem_lt_div", 64'(r8 < y), 1);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_q"}, q, 0);
        chk({tag, "_r"}, r, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dbz"}, dbz, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        longint t;
        int bc;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1;
        op(13, 3);
        op(15, 1);
        op(2, 5);
        op(15, 15);
        op(7, 0);
        op(9, 2);
        issue(13, 3, 1, t);
        repeat (2) @(negedge clk);
        a = 9;
        b = 4;
        sb.push_back(model(4, 9, 4, t + 50));
        while ($time < t + 50) @(posedge clk);
        #1;
        start = 0;
        wait_done(bc);
        chk("b2b_busy_cycles", bc, 4);
        issue(5, 2, 0, t);
        @(negedge clk);
        start = 1;
        a = 15;
        b = 1;
        @(negedge clk);
        start = 0;
        wait_done(bc);
        repeat (8) @(negedge clk);
        chk("pulse_ignored_sb_empty", sb.size(), 0);
        issue(13, 3, 0, t);
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        #1;
        check_zero("abort");
        void'(sb.pop_back());
        rst_n = 1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", sb.size(), 0);
        op(6, 4);
        for (int x = 0; x < 16; x++)
            for (int y = 1; y < 16; y++) op(4'(x), 4'(y));
        for (int i = 0; i < 20; i++) op(4'($urandom), 4'($urandom_range(0, 3)));
        for (int i = 0; i < 200; i++) op8(8'($urandom), (i % 25 == 0) ? 8'd0 : 8'($urandom));
        op8(8'd255, 8'd1);
        op8(8'd0, 8'd255);
        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size() + sb8.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
